// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XFER,
        ST_ABORT,
        ST_FLUSH,
        ST_GAP
    } state_t;

    localparam logic       SRC_ARP    = 1'b0;
    localparam logic       SRC_UDP    = 1'b1;
    localparam logic [7:0] ABORT_BYTE = 8'h00;
    localparam int         CNT_W      = 16;

endpackage

// File: rtl/eth_tx_stall_timer.sv
// Counts consecutive source-starved cycles of the granted frame and flags the cycle the limit is hit.
module eth_tx_stall_timer
    import eth_tx_pkg::*;
#(
    parameter int P_STALL_LIMIT = 64
) (
    input  logic CLK,
    input  logic I_RESET,
    input  logic enable,
    input  logic clear,
    input  logic starved,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(P_STALL_LIMIT - 1);

    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge CLK) begin
        if (I_RESET || clear) begin
            stall_cnt <= '0;
        end else if (enable && starved) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Fires in the starved cycle that brings the count up to the limit, so a
    // source that returns in that very cycle wins with its handshake.
    assign expired = enable && starved && (stall_cnt == LIMIT_M1);

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular two-way arbiter (ARP = source 0, UDP = source 1) onto one byte-wide MAC TX stream,
// with inter-frame gap enforcement and clean abort of frames whose source stalls mid-frame.
module eth_tx_arbiter
    import eth_tx_pkg::*;
#(
    parameter int P_GAP_CYCLES   = 12,
    parameter int P_STALL_LIMIT  = 64,
    parameter int P_ARP_PRIORITY = 1
) (
    input  logic        CLK,
    input  logic        I_RESET,
    input  logic        S0_AXIS_TVALID,
    input  logic [7:0]  S0_AXIS_TDATA,
    input  logic        S0_AXIS_TLAST,
    input  logic        S0_AXIS_TUSER,
    output logic        S0_AXIS_TREADY,
    input  logic        S1_AXIS_TVALID,
    input  logic [7:0]  S1_AXIS_TDATA,
    input  logic        S1_AXIS_TLAST,
    input  logic        S1_AXIS_TUSER,
    output logic        S1_AXIS_TREADY,
    output logic        M_AXIS_TVALID,
    output logic [7:0]  M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TUSER,
    input  logic        M_AXIS_TREADY,
    output logic [1:0]  O_GRANT,
    output logic        O_BUSY,
    output logic [15:0] O_ABORT_CNT
);

    localparam state_t           END_STATE = (P_GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
    localparam logic [CNT_W-1:0] GAP_LOAD  = (P_GAP_CYCLES > 0) ? CNT_W'(P_GAP_CYCLES - 1) : '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    state_t           state, state_n;
    logic             grant_idx, grant_n;
    logic             last_grant, last_n;
    logic             sent_any, sent_n;
    logic [CNT_W-1:0] abort_cnt, abort_n;
    logic [CNT_W-1:0] gap_cnt, gap_n;

    logic             g_tvalid, g_tlast, g_tuser;
    logic [7:0]       g_tdata;
    logic             hs_xfer, own_rdy, pick, stall_expired;

    assign g_tvalid = grant_idx ? S1_AXIS_TVALID : S0_AXIS_TVALID;
    assign g_tdata  = grant_idx ? S1_AXIS_TDATA  : S0_AXIS_TDATA;
    assign g_tlast  = grant_idx ? S1_AXIS_TLAST  : S0_AXIS_TLAST;
    assign g_tuser  = grant_idx ? S1_AXIS_TUSER  : S0_AXIS_TUSER;
    assign hs_xfer  = (state == ST_XFER) && g_tvalid && M_AXIS_TREADY;

    // Held clear throughout IDLE, which covers the entry into XFER.
    eth_tx_stall_timer #(
        .P_STALL_LIMIT(P_STALL_LIMIT)
    ) u_stall_timer (
        .CLK    (CLK),
        .I_RESET(I_RESET),
        .enable (state == ST_XFER),
        .clear  ((state == ST_IDLE) || hs_xfer),
        .starved(!g_tvalid),
        .expired(stall_expired)
    );

    always_ff @(posedge CLK) begin
        if (I_RESET) begin
            state      <= ST_IDLE;
            grant_idx  <= SRC_ARP;
            last_grant <= SRC_UDP;
            sent_any   <= 1'b0;
            abort_cnt  <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_n;
            grant_idx  <= grant_n;
            last_grant <= last_n;
            sent_any   <= sent_n;
            abort_cnt  <= abort_n;
            gap_cnt    <= gap_n;
        end
    end

    always_comb begin
        state_n       = state;
        grant_n       = grant_idx;
        last_n        = last_grant;
        sent_n        = sent_any;
        abort_n       = abort_cnt;
        gap_n         = gap_cnt;
        pick          = SRC_ARP;
        own_rdy       = 1'b0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = 8'h00;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TUSER  = 1'b0;
        O_GRANT       = 2'b00;

        case (state)
            ST_IDLE: begin
                if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
                    pick = (P_ARP_PRIORITY != 0) ? SRC_ARP : ~last_grant;
                end else begin
                    pick = S1_AXIS_TVALID ? SRC_UDP : SRC_ARP;
                end
                if (S0_AXIS_TVALID || S1_AXIS_TVALID) begin
                    state_n = ST_XFER;
                    grant_n = pick;
                    last_n  = pick;
                    sent_n  = 1'b0;
                end
            end
            ST_XFER: begin
                M_AXIS_TVALID = g_tvalid;
                M_AXIS_TDATA  = g_tdata;
                M_AXIS_TLAST  = g_tlast;
                M_AXIS_TUSER  = g_tuser;
                own_rdy       = M_AXIS_TREADY;
                O_GRANT       = grant_idx ? 2'b10 : 2'b01;
                if (hs_xfer) begin
                    sent_n = 1'b1;
                    if (g_tlast) begin
                        state_n = END_STATE;
                        gap_n   = GAP_LOAD;
                    end
                end else if (stall_expired) begin
                    // A frame that never started is simply released; nothing reached the MAC.
                    state_n = sent_any ? ST_ABORT : ST_IDLE;
                end
            end
            ST_ABORT: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = ABORT_BYTE;
                M_AXIS_TLAST  = 1'b1;
                M_AXIS_TUSER  = 1'b1;
                O_GRANT       = grant_idx ? 2'b10 : 2'b01;
                if (M_AXIS_TREADY) begin
                    abort_n = sat_inc(abort_cnt);
                    state_n = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                own_rdy = 1'b1;
                O_GRANT = grant_idx ? 2'b10 : 2'b01;
                if (g_tvalid && g_tlast) begin
                    state_n = END_STATE;
                    gap_n   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_n = gap_cnt - 16'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        S0_AXIS_TREADY = own_rdy && (grant_idx == SRC_ARP);
        S1_AXIS_TREADY = own_rdy && (grant_idx == SRC_UDP);
    end

    assign O_BUSY      = (state != ST_IDLE);
    assign O_ABORT_CNT = abort_cnt;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench: dut A (gap 12, stall 4, ARP priority) and dut B (gap 0, stall 4, round-robin).
module tb_eth_tx_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Source index i = 2*dut + src
    logic [3:0]  sv, sl, su;
    logic [31:0] sd;
    logic [1:0]  mr;

    wire         s0r_a, s1r_a, mv_a, ml_a, mu_a, busy_a;
    wire [7:0]   md_a;
    wire [1:0]   g_a;
    wire [15:0]  ac_a;
    wire         s0r_b, s1r_b, mv_b, ml_b, mu_b, busy_b;
    wire [7:0]   md_b;
    wire [1:0]   g_b;
    wire [15:0]  ac_b;
    wire [3:0]   trdy = {s1r_b, s0r_b, s1r_a, s0r_a};

    eth_tx_arbiter #(.P_GAP_CYCLES(12), .P_STALL_LIMIT(4), .P_ARP_PRIORITY(1)) u_dut_a (
        .CLK(clk), .I_RESET(rst),
        .S0_AXIS_TVALID(sv[0]), .S0_AXIS_TDATA(sd[7:0]), .S0_AXIS_TLAST(sl[0]), .S0_AXIS_TUSER(su[0]),
        .S0_AXIS_TREADY(s0r_a),
        .S1_AXIS_TVALID(sv[1]), .S1_AXIS_TDATA(sd[15:8]), .S1_AXIS_TLAST(sl[1]), .S1_AXIS_TUSER(su[1]),
        .S1_AXIS_TREADY(s1r_a),
        .M_AXIS_TVALID(mv_a), .M_AXIS_TDATA(md_a), .M_AXIS_TLAST(ml_a), .M_AXIS_TUSER(mu_a),
        .M_AXIS_TREADY(mr[0]), .O_GRANT(g_a), .O_BUSY(busy_a), .O_ABORT_CNT(ac_a)
    );

    eth_tx_arbiter #(.P_GAP_CYCLES(0), .P_STALL_LIMIT(4), .P_ARP_PRIORITY(0)) u_dut_b (
        .CLK(clk), .I_RESET(rst),
        .S0_AXIS_TVALID(sv[2]), .S0_AXIS_TDATA(sd[23:16]), .S0_AXIS_TLAST(sl[2]), .S0_AXIS_TUSER(su[2]),
        .S0_AXIS_TREADY(s0r_b),
        .S1_AXIS_TVALID(sv[3]), .S1_AXIS_TDATA(sd[31:24]), .S1_AXIS_TLAST(sl[3]), .S1_AXIS_TUSER(su[3]),
        .S1_AXIS_TREADY(s1r_b),
        .M_AXIS_TVALID(mv_b), .M_AXIS_TDATA(md_b), .M_AXIS_TLAST(ml_b), .M_AXIS_TUSER(mu_b),
        .M_AXIS_TREADY(mr[1]), .O_GRANT(g_b), .O_BUSY(busy_b), .O_ABORT_CNT(ac_b)
    );

    // Source entries: {kind[1:0], tuser, tlast, data}; kind 0=byte, 1=one idle cycle, 2=one-cycle valid pulse
    logic [11:0] q [4][$];
    int          rp [4];
    int          rmode [2];
    logic [3:0]  pres, hs;
    logic        tog;

    initial begin : drv
        logic [11:0] e;
        sv = '0; sl = '0; su = '0; sd = '0; mr = 2'b00; pres = '0; tog = 1'b0;
        for (int i = 0; i < 4; i++) rp[i] = 0;
        forever begin
            @(negedge clk);
            hs = sv & trdy;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (rst) begin
                    rp[i] = q[i].size();
                    pres[i] = 1'b0;
                end else if (pres[i] && rp[i] < q[i].size()) begin
                    e = q[i][rp[i]];
                    if (e[11:10] != 2'd0 || hs[i]) rp[i]++;
                end
                if (rp[i] < q[i].size()) begin
                    e = q[i][rp[i]];
                    sv[i] = (e[11:10] != 2'd1);
                    sd[i*8 +: 8] = e[7:0];
                    sl[i] = e[8];
                    su[i] = e[9];
                    pres[i] = 1'b1;
                end else begin
                    sv[i] = 1'b0;
                    sl[i] = 1'b0;
                    su[i] = 1'b0;
                    pres[i] = 1'b0;
                end
            end
            tog = ~tog;
            for (int d = 0; d < 2; d++) mr[d] = (rmode[d] == 0) ? 1'b1 : (rmode[d] == 1) ? tog : 1'b0;
        end
    end

    // Captured output beats: {grant, tuser, tlast, data}
    logic [11:0] cap_a [$];
    logic [11:0] cap_b [$];
    int          capc_a [$];
    int          cyc, idle_cyc_a, dual_rdy;
    logic        was_busy_a;

    initial begin : mon
        cyc = 0; idle_cyc_a = 0; dual_rdy = 0; was_busy_a = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (mv_a && mr[0]) begin
                    cap_a.push_back({g_a, mu_a, ml_a, md_a});
                    capc_a.push_back(cyc);
                end
                if (mv_b && mr[1]) cap_b.push_back({g_b, mu_b, ml_b, md_b});
                if ((s0r_a && s1r_a) || (s0r_b && s1r_b)) dual_rdy++;
                if (busy_a) was_busy_a = 1'b1;
                else if (was_busy_a) begin
                    idle_cyc_a = cyc;
                    was_busy_a = 1'b0;
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    function automatic int pending_all();
        int n = 0;
        for (int i = 0; i < 4; i++) n += q[i].size() - rp[i];
        return n;
    endfunction

    task automatic wait_idle();
        int k = 0;
        while ((busy_a || busy_b || pending_all() > 0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic push_frame(input int i, input int n, input int base);
        for (int k = 0; k < n; k++) q[i].push_back({2'b00, 1'b0, (k == n - 1), 8'(base + k)});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({s0r_a, s1r_a, mv_a, ml_a, mu_a, busy_a} !== 6'b0) begin bad++; $display("FAIL reset_ctl_a got=%b want=000000", {s0r_a, s1r_a, mv_a, ml_a, mu_a, busy_a}); end
        total++; if ({md_a, g_a, ac_a} !== 26'h0) begin bad++; $display("FAIL reset_val_a got=%h want=0", {md_a, g_a, ac_a}); end
        total++; if ({s0r_b, s1r_b, mv_b, ml_b, mu_b, busy_b} !== 6'b0) begin bad++; $display("FAIL reset_ctl_b got=%b want=000000", {s0r_b, s1r_b, mv_b, ml_b, mu_b, busy_b}); end
        total++; if ({md_b, g_b, ac_b} !== 26'h0) begin bad++; $display("FAIL reset_val_b got=%h want=0", {md_b, g_b, ac_b}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_arp_frame();
        int b0 = cap_a.size();
        int err = 0;
        logic s1seen = 1'b0;
        logic [11:0] e;
        push_frame(0, 42, 0);
        for (int k = 0; k < 200 && cap_a.size() < b0 + 42; k++) begin
            @(negedge clk);
            if (s1r_a) s1seen = 1'b1;
        end
        wait_idle();
        total++; if (cap_a.size() !== b0 + 42) begin bad++; $display("FAIL arp_len got=%0d want=%0d", cap_a.size() - b0, 42); end
        for (int k = 0; k < 42; k++) begin
            e = cap_a[b0 + k];
            if (e !== {2'b01, 1'b0, (k == 41), 8'(k)}) err++;
        end
        total++; if (err !== 0) begin bad++; $display("FAIL arp_bytes got=%0d bad beats want=0", err); end
        total++; if (cap_a[b0 + 41][8] !== 1'b1) begin bad++; $display("FAIL arp_tlast got=%b want=1", cap_a[b0 + 41][8]); end
        total++; if (s1seen !== 1'b0) begin bad++; $display("FAIL arp_s1_ready got=%b want=0", s1seen); end
        total++; if (idle_cyc_a - capc_a[b0 + 41] !== 13) begin bad++; $display("FAIL arp_gap got=%0d want=13", idle_cyc_a - capc_a[b0 + 41]); end
    endtask

    task automatic test_tie_break(input int d, input logic [11:0] exp_seq);
        int b0 = (d == 0) ? cap_a.size() : cap_b.size();
        int err = 0;
        int k0 = 0;
        int k1 = 0;
        logic [11:0] seq = '0;
        logic [11:0] e;
        logic [7:0] ed;
        for (int f = 0; f < 3; f++) begin
            push_frame(2 * d, 10, 8'h40 + f * 10);
            push_frame(2 * d + 1, 10, 8'h80 + f * 10);
        end
        wait_idle();
        total++; if (((d == 0) ? cap_a.size() : cap_b.size()) - b0 !== 60) begin bad++; $display("FAIL tie_len dut%0d got=%0d want=60", d, ((d == 0) ? cap_a.size() : cap_b.size()) - b0); end
        for (int j = 0; j < 60; j++) begin
            e = (d == 0) ? cap_a[b0 + j] : cap_b[b0 + j];
            ed = e[11] ? 8'(8'h80 + k1) : 8'(8'h40 + k0);
            if (e[7:0] !== ed || e[8] !== (((e[11] ? k1 : k0) % 10) == 9) || e[9] !== 1'b0) err++;
            if (e[11]) k1++; else k0++;
            if (e[8]) seq = {seq[9:0], e[11:10]};
        end
        total++; if (seq !== exp_seq) begin bad++; $display("FAIL tie_order dut%0d got=%b want=%b", d, seq, exp_seq); end
        total++; if (err !== 0) begin bad++; $display("FAIL tie_bytes dut%0d got=%0d bad beats want=0", d, err); end
    endtask

    task automatic test_backpressure();
        int b0 = cap_a.size();
        int err = 0;
        rmode[0] = 1;
        push_frame(1, 20, 8'h60);
        for (int k = 0; k < 300 && cap_a.size() < b0 + 20; k++) @(negedge clk);
        rmode[0] = 0;
        wait_idle();
        total++; if (cap_a.size() - b0 !== 20) begin bad++; $display("FAIL bp_len got=%0d want=20", cap_a.size() - b0); end
        for (int k = 0; k < 20; k++)
            if (cap_a[b0 + k] !== {2'b10, 1'b0, (k == 19), 8'(8'h60 + k)}) err++;
        total++; if (err !== 0) begin bad++; $display("FAIL bp_bytes got=%0d bad beats want=0", err); end
        total++; if (ac_a !== 16'd0) begin bad++; $display("FAIL bp_abort_cnt got=%0d want=0", ac_a); end
    endtask

    task automatic test_empty_stall();
        int b0 = cap_a.size();
        int nb = 0;
        logic [1:0] gseen = 2'b00;
        q[0].push_back({2'd2, 1'b0, 1'b0, 8'hAA});
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy_a) begin
                nb++;
                gseen = gseen | g_a;
            end
        end
        total++; if (nb !== 4) begin bad++; $display("FAIL empty_busy_cycles got=%0d want=4", nb); end
        total++; if (gseen !== 2'b01) begin bad++; $display("FAIL empty_grant got=%b want=01", gseen); end
        total++; if (cap_a.size() - b0 !== 0) begin bad++; $display("FAIL empty_out_beats got=%0d want=0", cap_a.size() - b0); end
        total++; if (ac_a !== 16'd0) begin bad++; $display("FAIL empty_abort_cnt got=%0d want=0", ac_a); end
    endtask

    task automatic test_stall_abort();
        int b0 = cap_a.size();
        int err = 0;
        for (int k = 0; k < 5; k++) q[1].push_back({2'd0, 1'b0, 1'b0, 8'(8'h10 + k)});
        for (int k = 0; k < 4; k++) q[1].push_back({2'd1, 1'b0, 1'b0, 8'h00});
        for (int k = 5; k < 8; k++) q[1].push_back({2'd0, 1'b0, (k == 7), 8'(8'h10 + k)});
        wait_idle();
        total++; if (cap_a.size() - b0 !== 6) begin bad++; $display("FAIL abort_len got=%0d want=6", cap_a.size() - b0); end
        for (int k = 0; k < 5; k++)
            if (cap_a[b0 + k] !== {2'b10, 1'b0, 1'b0, 8'(8'h10 + k)}) err++;
        total++; if (err !== 0) begin bad++; $display("FAIL abort_head_bytes got=%0d bad beats want=0", err); end
        total++; if (cap_a[b0 + 5] !== 12'b10_1_1_00000000) begin bad++; $display("FAIL abort_beat got=%h want=%h", cap_a[b0 + 5], 12'hB00); end
        total++; if (ac_a !== 16'd1) begin bad++; $display("FAIL abort_cnt got=%0d want=1", ac_a); end
        total++; if (q[1].size() - rp[1] !== 0) begin bad++; $display("FAIL abort_flush_left got=%0d want=0", q[1].size() - rp[1]); end
    endtask

    task automatic test_reset_mid_frame();
        int b0 = cap_a.size();
        int b1;
        int err = 0;
        int nl = 0;
        push_frame(0, 30, 8'hC0);
        for (int k = 0; k < 100 && cap_a.size() < b0 + 7; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if ({s0r_a, s1r_a, mv_a, ml_a, mu_a, busy_a} !== 6'b0) begin bad++; $display("FAIL midrst_ctl got=%b want=000000", {s0r_a, s1r_a, mv_a, ml_a, mu_a, busy_a}); end
        total++; if ({md_a, g_a} !== 10'h0) begin bad++; $display("FAIL midrst_data got=%h want=0", {md_a, g_a}); end
        total++; if (ac_a !== 16'd0) begin bad++; $display("FAIL midrst_abort_cnt got=%0d want=0", ac_a); end
        rst = 1'b0;
        for (int k = b0; k < cap_a.size(); k++) if (cap_a[k][8]) nl++;
        total++; if (nl !== 0) begin bad++; $display("FAIL midrst_truncated_tlast got=%0d want=0", nl); end
        repeat (2) @(negedge clk);
        b1 = cap_a.size();
        push_frame(0, 8, 8'h30);
        wait_idle();
        total++; if (cap_a.size() - b1 !== 8) begin bad++; $display("FAIL fresh_len got=%0d want=8", cap_a.size() - b1); end
        for (int k = 0; k < 8; k++)
            if (cap_a[b1 + k] !== {2'b01, 1'b0, (k == 7), 8'(8'h30 + k)}) err++;
        total++; if (err !== 0) begin bad++; $display("FAIL fresh_bytes got=%0d bad beats want=0", err); end
    endtask

    initial begin
        rmode[0] = 0;
        rmode[1] = 0;
        test_reset();
        test_arp_frame();
        test_tie_break(0, 12'b01_01_01_10_10_10);
        test_tie_break(1, 12'b01_10_01_10_01_10);
        test_backpressure();
        test_empty_stall();
        test_stall_abort();
        test_reset_mid_frame();
        total++; if (dual_rdy !== 0) begin bad++; $display("FAIL both_tready_high got=%0d cycles want=0", dual_rdy); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Frame-granular two-way arbiter that shares the single byte-wide Ethernet TX stream between the ARP responder (source 0) and the UDP transmit path (source 1). It sits between those two frame producers and the MAC TX interface. It grants one complete frame at a time, enforces a minimum idle gap between frames, and aborts a frame cleanly if the granted source stalls mid-frame.

## Interface
Parameters:
- P_GAP_CYCLES, 12: idle cycles forced after each frame's TLAST handshake; 0 allowed.
- P_STALL_LIMIT, 64: consecutive source-starved cycles in a frame before abort; range 1..65535.
- P_ARP_PRIORITY, 1: 1 = source 0 wins every tie; 0 = round-robin on ties.

Ports:
- CLK  in  1  clock.
- I_RESET  in  1  synchronous, active-high reset.
- S0_AXIS_TVALID/TDATA/TLAST/TUSER  in  1/8/1/1  ARP frame stream; TUSER=1 marks a bad frame.
- S0_AXIS_TREADY  out  1
- S1_AXIS_TVALID/TDATA/TLAST/TUSER  in  1/8/1/1  UDP frame stream.
- S1_AXIS_TREADY  out  1
- M_AXIS_TVALID/TDATA/TLAST/TUSER  out  1/8/1/1  to MAC.
- M_AXIS_TREADY  in  1
- O_GRANT  out  2  one-hot current owner; 00 when none.
- O_BUSY  out  1  state is not IDLE.
- O_ABORT_CNT  out  16  saturating count of injected aborts.

## Operation
- States: IDLE, XFER, ABORT, FLUSH, GAP.
- IDLE:
  - If any S*_TVALID is high, latch the grant and go to XFER next cycle.
  - Tie resolution: P_ARP_PRIORITY=1 picks S0. P_ARP_PRIORITY=0 picks the source not granted last.
  - The last-granted pointer resets to S1, so S0 wins the first tie.
- XFER: combinational pass-through.
  - M_AXIS_TVALID/TDATA/TLAST/TUSER follow the granted source.
  - Granted TREADY = M_AXIS_TREADY; the other TREADY = 0.
  - On a handshake with TLAST=1: go to GAP, or to IDLE if P_GAP_CYCLES=0.
- Stall counter (16-bit):
  - Increments each XFER cycle in which the granted TVALID=0.
  - Clears on any handshake and on entry to XFER.
  - Cycles where TVALID=1 but M_AXIS_TREADY=0 do not count.
- Stall limit reached (counter == P_STALL_LIMIT):
  - If at least one byte of the frame was sent: go to ABORT.
  - If no byte was sent: go to IDLE, release the grant, no injection.
  - If the limit is reached in the same cycle the source raises TVALID, the handshake wins and the counter clears.
- ABORT:
  - Drive M_AXIS_TVALID=1, TDATA=0x00, TLAST=1, TUSER=1.
  - Hold until M_AXIS_TREADY; then increment O_ABORT_CNT (saturating at 0xFFFF) and go to FLUSH.
- FLUSH:
  - Granted TREADY=1 and M_AXIS_TVALID=0.
  - Discard bytes until a TLAST=1 handshake, then go to GAP or IDLE.
- GAP: M_AXIS_TVALID=0, both TREADY=0, for exactly P_GAP_CYCLES cycles, then IDLE.
- Source TUSER is passed through unmodified; the arbiter never drops a frame on TUSER.

## Timing
- Reset values: all TREADY=0, M_AXIS_TVALID=0, TDATA=0, TLAST=0, TUSER=0, O_GRANT=00, O_BUSY=0, O_ABORT_CNT=0, state IDLE.
- Arbitration latency: 1 cycle from TVALID seen in IDLE to the first possible handshake in XFER.
- XFER data path has zero latency; full throughput is 1 byte/cycle.
- Frame-to-frame spacing: last TLAST handshake, then P_GAP_CYCLES idle cycles, then 1 IDLE cycle, then the next first byte.
- Grant does not change mid-frame. Only the owner's TREADY may be high.
- Master handshake rule: once M_AXIS_TVALID is high with M_AXIS_TREADY low, TDATA/TLAST/TUSER must be held stable.
  - Pass-through relies on sources obeying AXIS.
  - In ABORT the arbiter holds the values itself.
- Reset mid-frame: the frame is truncated without TLAST, and all state returns to reset values the next cycle. The MAC must share I_RESET.

## Structure
- Package eth_tx_pkg:
  - state enum (IDLE, XFER, ABORT, FLUSH, GAP)
  - source index constants SRC_ARP=0, SRC_UDP=1
  - ABORT_BYTE=8'h00
  - 16-bit counter width constant
- Sub-module eth_tx_stall_timer holds the stall counter and limit compare.
  - Inputs: enable, clear, starved.
  - Output: expired.

## Test plan
- Single ARP frame of 42 bytes 0x00..0x29, M_AXIS_TREADY=1: output is identical, TLAST on byte 41, S1_AXIS_TREADY=0 throughout, O_GRANT=01; then 12 GAP cycles.
- Both sources valid simultaneously, P_ARP_PRIORITY=0, three rounds of 10-byte frames: grant order S0, S1, S0, S1, S0, S1. With P_ARP_PRIORITY=1: all S0 frames are granted first.
- M_AXIS_TREADY toggled 1/0 every cycle during a 20-byte UDP frame: no byte lost or duplicated, no abort, O_ABORT_CNT=0.
- P_STALL_LIMIT=4, S1 sends 5 bytes then drops TVALID for 4 cycles:
  - Output is 5 bytes followed by 0x00 with TLAST=1 and TUSER=1, and O_ABORT_CNT=1.
  - The remaining source bytes up to TLAST are consumed with M_AXIS_TVALID=0.
- P_STALL_LIMIT=4, S0 granted but never presents a byte: grant returns to IDLE after 4 starved cycles, with no injection and O_ABORT_CNT=0.
- I_RESET pulsed for 1 cycle at byte 7 of a 30-byte frame: the next cycle shows all outputs at reset values. A subsequent fresh frame passes intact.
